multi_cycle_micro: RTL and testbench

//  Multi-cycle MIPS-subset core: successor to the single-cycle micro top. One FSM sequences

---
 rtl/multi_cycle_micro.sv | 214 +++++++++++++++++++++
 tb/tb_multi_cycle_micro.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_micro.sv
// Multi-cycle MIPS-subset core: one FSM sequences fetch, decode, execute, memory and
// write-back over a single shared req/ready memory port, with a retired-instruction counter.
module multi_cycle_micro #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             reset,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ready,
   output logic [31:0]      pc,
   output logic             retire,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             trap,
   output logic [3:0]       state_dbg
);
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_ADDR   = 4'd3,
      S_EXEC_I = 4'd4,
      S_MEM_RD = 4'd5,
      S_MEM_WR = 4'd6,
      S_WB_R   = 4'd7,
      S_WB_I   = 4'd8,
      S_WB_MEM = 4'd9,
      S_TRAP   = 4'd10
   } state_t;

   state_t      state;
   logic [31:0] ir, a, b, alu_out, mdr;
   logic [31:0] regs [0:31];

   // Instruction fields and decode-time helpers; regs[0] is never written so it reads 0.
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_sext, rs_val, rt_val, branch_tgt, jump_tgt, eff_addr, alu_r, decode_pc;
   logic        legal_r, taken, decode_done;
   logic        unused_shamt;

   assign opcode       = ir[31:26];
   assign rs           = ir[25:21];
   assign rt           = ir[20:16];
   assign rd           = ir[15:11];
   assign funct        = ir[5:0];
   assign unused_shamt = ^ir[10:6];
   assign imm_sext     = {{16{ir[15]}}, ir[15:0]};
   assign rs_val       = regs[rs];
   assign rt_val       = regs[rt];
   assign branch_tgt   = pc + {imm_sext[29:0], 2'b00};
   assign jump_tgt     = {pc[31:28], ir[25:0], 2'b00};
   assign eff_addr     = a + imm_sext;
   assign taken        = (opcode == OP_BEQ) ? (rs_val == rt_val) : (rs_val != rt_val);
   assign legal_r      = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                         (funct == FN_OR)  || (funct == FN_SLT);
   assign decode_done  = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_J) ||
                         (opcode == OP_JAL) || ((opcode == OP_R) && (funct == FN_JR));
   assign state_dbg    = state;

   always_comb begin
      decode_pc = rs_val;
      case (opcode)
         OP_BEQ, OP_BNE: decode_pc = taken ? branch_tgt : pc;
         OP_J, OP_JAL:   decode_pc = jump_tgt;
         default:        decode_pc = rs_val;
      endcase
   end

   always_comb begin
      alu_r = '0;
      case (funct)
         FN_ADD:  alu_r = a + b;
         FN_SUB:  alu_r = a - b;
         FN_AND:  alu_r = a & b;
         FN_OR:   alu_r = a | b;
         FN_SLT:  alu_r = {31'b0, $signed(a) < $signed(b)};
         default: alu_r = '0;
      endcase
   end

   // Retire the current instruction and launch the next fetch in the same edge.
   task automatic finish_instr(input logic [31:0] next_pc);
      pc          <= next_pc;
      mem_req     <= 1'b1;
      mem_we      <= 1'b0;
      mem_addr    <= next_pc;
      retire      <= 1'b1;
      retired_cnt <= retired_cnt + CNT_W'(1);
      state       <= S_FETCH;
   endtask

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state       <= S_FETCH;
         pc          <= RESET_PC;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= RESET_PC;
         mem_wdata   <= '0;
         retire      <= 1'b0;
         retired_cnt <= '0;
         trap        <= 1'b0;
         ir          <= '0;
         a           <= '0;
         b           <= '0;
         alu_out     <= '0;
         mdr         <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         retire <= 1'b0;
         case (state)
            S_FETCH: begin
               // First cycle out of reset only raises the request.
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
               end else if (mem_ready) begin
                  ir      <= mem_rdata;
                  pc      <= pc + 32'd4;
                  mem_req <= 1'b0;
                  state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               a       <= rs_val;
               b       <= rt_val;
               alu_out <= branch_tgt;
               if (decode_done) begin
                  if (opcode == OP_JAL) regs[31] <= pc;
                  finish_instr(decode_pc);
               end else if ((opcode == OP_R) && legal_r) begin
                  state <= S_EXEC_R;
               end else if (opcode == OP_ADDI) begin
                  state <= S_EXEC_I;
               end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                  state <= S_ADDR;
               end else begin
                  trap  <= 1'b1;
                  state <= S_TRAP;
               end
            end
            S_EXEC_R: begin
               alu_out <= alu_r;
               state   <= S_WB_R;
            end
            S_WB_R: begin
               if (rd != 5'd0) regs[rd] <= alu_out;
               finish_instr(pc);
            end
            S_EXEC_I: begin
               alu_out <= eff_addr;
               state   <= S_WB_I;
            end
            S_WB_I: begin
               if (rt != 5'd0) regs[rt] <= alu_out;
               finish_instr(pc);
            end
            S_ADDR: begin
               alu_out <= eff_addr;
               if (eff_addr[1:0] != 2'b00) begin
                  trap  <= 1'b1;
                  state <= S_TRAP;
               end else begin
                  mem_req   <= 1'b1;
                  mem_addr  <= eff_addr;
                  mem_we    <= (opcode == OP_SW);
                  mem_wdata <= b;
                  state     <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
               end
            end
            S_MEM_RD: begin
               if (mem_ready) begin
                  mdr     <= mem_rdata;
                  mem_req <= 1'b0;
                  state   <= S_WB_MEM;
               end
            end
            S_WB_MEM: begin
               if (rt != 5'd0) regs[rt] <= mdr;
               finish_instr(pc);
            end
            S_MEM_WR: begin
               if (mem_ready) finish_instr(pc);
            end
            default: begin
               trap    <= 1'b1;
               mem_req <= 1'b0;
               state   <= S_TRAP;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_multi_cycle_micro.sv
// Directed bench for multi_cycle_micro: behavioural memory with optional wait states on
// low-address data reads, a transfer log, and table-driven ALU/trap vectors.
`timescale 1ns/1ps
module tb_multi_cycle_micro;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mem_req, mem_we, mem_ready = 1'b0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
   logic        retire, trap;
   logic [31:0] retired_cnt;
   logic [3:0]  state_dbg;

   always #5 clk = ~clk;

   multi_cycle_micro #(.RESET_PC(32'h100), .CNT_W(32)) dut (
      .CLK(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
      .retire(retire), .retired_cnt(retired_cnt), .trap(trap), .state_dbg(state_dbg));

   logic [31:0] mem [0:255];
   int          data_delay = 0;
   int          wait_cnt = 0, cyc = 0, req8_cycles = 0, retire_cycles = 0;
   int          checks = 0, failures = 0;
   logic [31:0] log_addr[$], log_wdata[$], log_cnt[$];
   logic        log_we[$];
   int          log_cyc[$];

   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) cyc <= cyc + 1;

   // Memory responder: decides ready mid-cycle so it is stable at the next rising edge.
   always @(negedge clk) begin
      if (mem_req && !mem_we && mem_addr == 32'h8) req8_cycles++;
      if (retire === 1'b1) retire_cycles++;
      if (mem_req === 1'b1 && (mem_we || mem_addr >= 32'h20 || wait_cnt >= data_delay)) begin
         mem_ready = 1'b1;
         wait_cnt  = 0;
         log_addr.push_back(mem_addr);
         log_we.push_back(mem_we);
         log_wdata.push_back(mem_wdata);
         log_cyc.push_back(cyc);
         log_cnt.push_back(retired_cnt);
      end else begin
         mem_ready = 1'b0;
         if (mem_req === 1'b1) wait_cnt++;
         else wait_cnt = 0;
      end
   end

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction
   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] target);
      return {op, target[27:2]};
   endfunction

   function automatic int find_store(input logic [31:0] addr, input int from);
      for (int i = from; i < log_addr.size(); i++)
         if (log_we[i] && log_addr[i] == addr) return i;
      return -1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic put(input logic [31:0] addr, input logic [31:0] data);
      mem[addr[9:2]] = data;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   endtask

   // Two rising edges with reset low; returns at the falling edge after release.
   task automatic do_reset();
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      @(negedge clk) reset = 1'b1;
   endtask

   typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } xfer_t;
   typedef struct { logic is_addi; logic [5:0] fn; logic [31:0] a, b, exp; } alu_vec_t;

   xfer_t       exp_x [19];
   alu_vec_t    alu_v [11];
   logic [31:0] bad_i [4];
   int          base, rbase, idx, req8_base;

   initial begin
      exp_x = '{
         '{32'h100, 1'b0, 32'h0}, '{32'h104, 1'b0, 32'h0}, '{32'h108, 1'b0, 32'h0},
         '{32'h10C, 1'b0, 32'h0}, '{32'h000, 1'b1, 32'd12}, '{32'h110, 1'b0, 32'h0},
         '{32'h008, 1'b0, 32'h0}, '{32'h114, 1'b0, 32'h0}, '{32'h00C, 1'b1, 32'hDEADBEEF},
         '{32'h118, 1'b0, 32'h0}, '{32'h11C, 1'b0, 32'h0}, '{32'h020, 1'b0, 32'h0},
         '{32'h080, 1'b0, 32'h0}, '{32'h024, 1'b0, 32'h0}, '{32'h010, 1'b1, 32'h24},
         '{32'h028, 1'b0, 32'h0}, '{32'h040, 1'b0, 32'h0}, '{32'h040, 1'b0, 32'h0},
         '{32'h040, 1'b0, 32'h0}};
      alu_v = '{
         '{1'b0, 6'h20, 32'd5,          32'd7,          32'd12},
         '{1'b0, 6'h20, 32'hFFFFFFFF,   32'd1,          32'd0},
         '{1'b0, 6'h22, 32'd3,          32'd5,          32'hFFFFFFFE},
         '{1'b0, 6'h22, 32'd0,          32'd1,          32'hFFFFFFFF},
         '{1'b0, 6'h24, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000},
         '{1'b0, 6'h25, 32'h00000F00,   32'h000000F0,   32'h00000FF0},
         '{1'b0, 6'h2A, 32'hFFFFFFFF,   32'd1,          32'd1},
         '{1'b0, 6'h2A, 32'd1,          32'hFFFFFFFF,   32'd0},
         '{1'b0, 6'h2A, 32'h80000000,   32'h7FFFFFFF,   32'd1},
         '{1'b0, 6'h2A, 32'd5,          32'd5,          32'd0},
         '{1'b1, 6'h00, 32'd10,         32'h0000FFFD,   32'd7}};
      bad_i[0] = {6'h3F, 26'd0};
      bad_i[1] = enc_r(5'd1, 5'd2, 5'd3, 6'h21);
      bad_i[2] = enc_i(6'h23, 5'd0, 5'd6, 16'd2);
      bad_i[3] = enc_i(6'h2B, 5'd0, 5'd6, 16'd1);

      // Main program: arithmetic, store, delayed load, branches and jumps, then a beq loop.
      clear_mem();
      put(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
      put(32'h104, enc_i(6'h08, 5'd0, 5'd2, 16'd7));
      put(32'h108, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
      put(32'h10C, enc_i(6'h2B, 5'd0, 5'd3, 16'd0));
      put(32'h110, enc_i(6'h23, 5'd0, 5'd4, 16'd8));
      put(32'h114, enc_i(6'h2B, 5'd0, 5'd4, 16'd12));
      put(32'h118, enc_i(6'h05, 5'd0, 5'd0, 16'd7));
      put(32'h11C, enc_j(6'h02, 32'h20));
      put(32'h020, enc_j(6'h03, 32'h80));
      put(32'h080, enc_r(5'd31, 5'd0, 5'd0, 6'h08));
      put(32'h024, enc_i(6'h2B, 5'd0, 5'd31, 16'd16));
      put(32'h028, enc_j(6'h02, 32'h40));
      put(32'h040, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
      put(32'h008, 32'hDEADBEEF);
      data_delay = 3;
      do_reset();
      check("rst_pc", pc, 32'h100);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_cnt", retired_cnt, 32'd0);
      check("rst_trap", 32'(trap), 32'd0);
      check("rst_retire", 32'(retire), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      base = log_addr.size();
      rbase = retire_cycles;
      req8_base = req8_cycles;
      @(negedge clk);
      check("first_req", 32'(mem_req), 32'd1);
      check("first_addr", mem_addr, 32'h100);
      repeat (70) @(negedge clk);
      #1;
      check("retire_pulses", retired_cnt, 32'(retire_cycles - rbase));
      check("log_len_ok", 32'(log_addr.size() >= base + 19), 32'd1);
      if (log_addr.size() >= base + 19) begin
         for (int i = 0; i < 19; i++) begin
            check($sformatf("xfer%0d_addr", i), log_addr[base+i], exp_x[i].addr);
            check($sformatf("xfer%0d_we", i), 32'(log_we[base+i]), 32'(exp_x[i].we));
            if (exp_x[i].we) check($sformatf("xfer%0d_wdata", i), log_wdata[base+i], exp_x[i].wdata);
         end
         check("cnt_after_16cyc", log_cnt[base+5], 32'd4);
         check("cnt_after_12cyc", log_cnt[base+3], 32'd3);
         check("four_instr_cycles", 32'(log_cyc[base+5] - log_cyc[base]), 32'd16);
         check("lw_total_cycles", 32'(log_cyc[base+7] - log_cyc[base+5]), 32'd8);
      end
      check("lw_req_held", 32'(req8_cycles - req8_base), 32'd4);
      data_delay = 0;

      // Reset clears the register file: $3 was 12, a store of $3 must now write 0.
      clear_mem();
      put(32'h100, enc_i(6'h2B, 5'd0, 5'd3, 16'd4));
      put(32'h104, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
      do_reset();
      base = log_addr.size();
      repeat (12) @(negedge clk);
      idx = find_store(32'h4, base);
      check("regclr_store_seen", 32'(idx >= 0), 32'd1);
      if (idx >= 0) check("regclr_wdata", log_wdata[idx], 32'd0);

      // ALU vectors: operands loaded from memory, result stored to 0x18.
      for (int i = 0; i < 11; i++) begin
         clear_mem();
         put(32'h010, alu_v[i].a);
         put(32'h014, alu_v[i].b);
         put(32'h100, enc_i(6'h23, 5'd0, 5'd1, 16'h10));
         put(32'h104, enc_i(6'h23, 5'd0, 5'd2, 16'h14));
         put(32'h108, alu_v[i].is_addi ? enc_i(6'h08, 5'd1, 5'd3, alu_v[i].b[15:0])
                                       : enc_r(5'd1, 5'd2, 5'd3, alu_v[i].fn));
         put(32'h10C, enc_i(6'h2B, 5'd0, 5'd3, 16'h18));
         put(32'h110, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
         do_reset();
         base = log_addr.size();
         repeat (30) @(negedge clk);
         idx = find_store(32'h18, base);
         check($sformatf("alu%0d_store_seen", i), 32'(idx >= 0), 32'd1);
         if (idx >= 0) check($sformatf("alu%0d_result", i), log_wdata[idx], alu_v[i].exp);
      end

      // Illegal opcode after one good instruction: sticky trap, count frozen.
      clear_mem();
      put(32'h100, enc_i(6'h08, 5'd0, 5'd5, 16'd1));
      put(32'h104, {6'h3F, 26'd0});
      do_reset();
      base = log_addr.size();
      repeat (20) @(negedge clk);
      check("trap_set", 32'(trap), 32'd1);
      check("trap_state", 32'(state_dbg), 32'd10);
      check("trap_cnt", retired_cnt, 32'd1);
      repeat (10) @(negedge clk);
      check("trap_sticky", 32'(trap), 32'd1);
      check("trap_no_req", 32'(mem_req), 32'd0);
      check("trap_xfers", 32'(log_addr.size() - base), 32'd2);
      do_reset();
      check("trap_cleared", 32'(trap), 32'd0);

      // Single trapping instruction at the reset PC: no retire, no data access.
      for (int i = 0; i < 4; i++) begin
         clear_mem();
         put(32'h100, bad_i[i]);
         do_reset();
         base = log_addr.size();
         repeat (15) @(negedge clk);
         check($sformatf("bad%0d_trap", i), 32'(trap), 32'd1);
         check($sformatf("bad%0d_cnt", i), retired_cnt, 32'd0);
         check($sformatf("bad%0d_req", i), 32'(mem_req), 32'd0);
         check($sformatf("bad%0d_xfers", i), 32'(log_addr.size() - base), 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
